dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 68 ++++++
 tb/tb_dmem_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU MEM stage and a debug/loader port,
// with starvation-bounded debug priority and an exclusive debug lock.
module dmem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [6:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [6:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic        dbg_lock,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [6:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic {SHARED, LOCKED} state_t;
  typedef enum logic [1:0] {NONE, CPU, DBG} owner_t;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  state_t state, state_next;
  owner_t owner, owner_next;
  logic [3:0] starve_cnt, starve_next;
  logic [31:0] cpu_rdata_q;
  logic dbg_win, cpu_win;
  always_comb begin
    dbg_win = RSTn && dbg_req && (state == LOCKED || !cpu_req || starve_cnt == SMAX);
    cpu_win = RSTn && state == SHARED && cpu_req && !dbg_win;
    cpu_stall = RSTn && cpu_req && !cpu_win;
    dbg_gnt = dbg_win;
    mem_en = dbg_win || cpu_win;
    mem_we = dbg_win ? dbg_we : (cpu_win ? cpu_we : 1'b0);
    mem_addr = dbg_win ? dbg_addr : cpu_addr;
    mem_wdata = dbg_win ? dbg_wdata : cpu_wdata;
    // a lock release still arbitrates this cycle under LOCKED rules; SHARED resumes next cycle
    state_next = state == SHARED ? ((dbg_win && dbg_lock) ? LOCKED : SHARED)
                                 : (dbg_lock ? LOCKED : SHARED);
    starve_next = (dbg_req && cpu_win) ? ((starve_cnt == SMAX) ? SMAX : starve_cnt + 4'd1) : 4'd0;
    owner_next = (dbg_win && !dbg_we) ? DBG : ((cpu_win && !cpu_we) ? CPU : NONE);
    // read data returned during reset is discarded
    dbg_rvalid = RSTn && owner == DBG;
    dbg_rdata = mem_rdata;
    cpu_rdata = (RSTn && owner == CPU) ? mem_rdata : cpu_rdata_q;
  end
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state <= SHARED;
      owner <= NONE;
      starve_cnt <= 4'd0;
      cpu_rdata_q <= 32'd0;
    end else begin
      state <= state_next;
      owner <= owner_next;
      starve_cnt <= starve_next;
      cpu_rdata_q <= cpu_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed steps against a behavioural 1-cycle-latency memory, with read data
// predicted from a reference memory and scoreboarded per port.
module tb_dmem_arbiter;
  logic CLK = 1'b0, RSTn = 1'b0;
  logic cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0, dbg_lock = 0;
  logic [6:0] cpu_addr = '0, dbg_addr = '0;
  logic [31:0] cpu_wdata = '0, dbg_wdata = '0;
  logic [31:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic cpu_stall, dbg_gnt, dbg_rvalid, mem_en, mem_we;
  logic [6:0] mem_addr;
  bit [31:0] mem [128];
  bit written [128];
  logic [31:0] ref_mem [128];
  logic [31:0] cpu_q[$], dbg_q[$];
  logic [31:0] last_cpu = '0;
  bit cpu_pend = 0, dbg_pend = 0;
  int n_checks = 0, n_pass = 0;

  always #5 CLK = ~CLK;

  dmem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_val(input logic [6:0] a);
    return {25'h0C0DE00, a} ^ 32'h5A000000;
  endfunction

  always @(posedge CLK)
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end else
        mem_rdata <= written[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // one clock: ec/ed = whether the CPU / debug port is expected to win this cycle
  task automatic step(input string tag, input bit ec, input bit ed);
    @(negedge CLK);
    chk({tag, ":dbg_gnt"}, {31'd0, dbg_gnt}, {31'd0, ed});
    chk({tag, ":cpu_stall"}, {31'd0, cpu_stall}, {31'd0, RSTn && cpu_req && !ec});
    chk({tag, ":mem_en"}, {31'd0, mem_en}, {31'd0, ec || ed});
    chk({tag, ":mem_we"}, {31'd0, mem_we}, {31'd0, ed ? dbg_we : (ec ? cpu_we : 1'b0)});
    if (ec || ed) chk({tag, ":mem_addr"}, {25'd0, mem_addr}, {25'd0, ed ? dbg_addr : cpu_addr});
    if (!RSTn) begin
      chk({tag, ":rst_rvalid"}, {31'd0, dbg_rvalid}, 32'd0);
      dbg_q.delete();
      cpu_q.delete();
      dbg_pend = 0;
      cpu_pend = 0;
      last_cpu = '0;
    end else begin
      chk({tag, ":dbg_rvalid"}, {31'd0, dbg_rvalid}, {31'd0, dbg_pend});
      if (dbg_pend) chk({tag, ":dbg_rdata"}, dbg_rdata, dbg_q.size() ? dbg_q.pop_front() : 32'bx);
      if (cpu_pend) last_cpu = cpu_q.size() ? cpu_q.pop_front() : 32'bx;
      chk({tag, ":cpu_rdata"}, cpu_rdata, last_cpu);
      dbg_pend = ed && !dbg_we;
      cpu_pend = ec && !cpu_we;
      if (ed) begin
        if (dbg_we) ref_mem[dbg_addr] = dbg_wdata;
        else dbg_q.push_back(ref_mem[dbg_addr]);
      end
      if (ec) begin
        if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
        else cpu_q.push_back(ref_mem[cpu_addr]);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = init_val(7'(i));
    repeat (2) @(posedge CLK);
    #1;
    step("rst_idle", 0, 0);
    cpu_req = 1; dbg_req = 1;
    step("rst_forced", 0, 0);
    // CPU store then load with no debug traffic
    RSTn = 1; dbg_req = 0; cpu_we = 1; cpu_addr = 7'd5; cpu_wdata = 32'hA5A5A5A5;
    step("cpu_st0", 1, 0);
    step("cpu_st1", 1, 0);
    cpu_we = 0;
    step("cpu_ld5", 1, 0);
    cpu_req = 0;
    step("cpu_ret", 0, 0);
    step("cpu_hold", 0, 0);
    // both ports contending: debug forced through every fifth cycle
    cpu_req = 1; cpu_addr = 7'd7; dbg_req = 1; dbg_we = 0; dbg_addr = 7'd8;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) step("starve_cpu", 1, 0);
      step("starve_dbg", 0, 1);
    end
    cpu_req = 0; dbg_req = 0;
    step("gap", 0, 0);
    // locked debug session with the CPU requesting throughout
    cpu_req = 1; dbg_req = 1; dbg_we = 1; dbg_addr = 7'd10; dbg_wdata = 32'h1234; dbg_lock = 1;
    for (int k = 0; k < 4; k++) step("pre_lock", 1, 0);
    step("lock_wr", 0, 1);
    dbg_we = 0;
    for (int k = 0; k < 3; k++) step("lock_rd", 0, 1);
    dbg_req = 0;
    step("lock_idle", 0, 0);
    dbg_lock = 0;
    step("unlock", 0, 0);
    step("post_unlock", 1, 0);
    // CPU read immediately followed by debug read
    cpu_addr = 7'd3;
    step("b2b_cpu", 1, 0);
    cpu_req = 0; dbg_req = 1; dbg_addr = 7'd4;
    step("b2b_dbg", 0, 1);
    dbg_req = 0;
    step("b2b_ret", 0, 0);
    // reset while locked with a debug read in flight
    dbg_req = 1; dbg_lock = 1; dbg_addr = 7'd4;
    step("rl_lock", 0, 1);
    cpu_req = 1; dbg_addr = 7'd6;
    step("rl_rd", 0, 1);
    RSTn = 0;
    step("rl_rst", 0, 0);
    RSTn = 1; dbg_req = 0; dbg_lock = 0; cpu_addr = 7'd5;
    step("rl_cpu", 1, 0);
    cpu_req = 0;
    step("rl_ret", 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
